// File: rtl/eth_send_pkg.sv
// Shared definitions for the Ethernet send arbiter: FSM state encoding and
// helpers that size the staging window and the channel-select field.
package eth_send_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_GRANT = 3'd1;
  localparam logic [STATE_W-1:0] ST_COPY  = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND  = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  // Largest packet the W5500 TX staging window can hold.
  function automatic int max_len(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_MAX_LEN = max_len(DEF_ADDR_W);

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker: the lowest requester at or above ptr wins,
// otherwise the lowest requester overall (wrap-around).
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Masked priority search with an unmasked fallback.
  always_comb begin
    // NOTE: every output gets a default before the loops, so no path leaves idx unassigned and no latch is inferred.
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/eth_send_arbiter.sv
// Multiplexes N_CH packet sources onto one W5500 TCP socket: picks a channel,
// copies its bytes into the TX staging buffer, issues the send command and
// waits for completion, acknowledging or dropping the packet.
module eth_send_arbiter
  import eth_send_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int LEN_W   = 16,
  parameter int ADDR_W  = 11,
  parameter int TMO_CYC = 5_000_000
) (
  input  logic                    i_clk_50m,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_ch_req,
  input  logic [N_CH*LEN_W-1:0]   i_ch_len,
  output logic [N_CH-1:0]         o_ch_ack,
  output logic [N_CH-1:0]         o_ch_drop,
  output logic                    o_rd_en,
  output logic [sel_w(N_CH)-1:0]  o_rd_sel,
  output logic [ADDR_W-1:0]       o_rd_addr,
  input  logic [N_CH*8-1:0]       i_rd_data,
  output logic                    o_send_data_req,
  output logic [7:0]              o_send_data,
  output logic [ADDR_W-1:0]       o_send_wraddr,
  output logic                    o_send_req,
  output logic [LEN_W-1:0]        o_send_num,
  input  logic                    i_send_sig,
  input  logic                    i_connect_state,
  output logic                    o_busy
);

  localparam int SEL_W = sel_w(N_CH);
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  // LEN_W is assumed wider than ADDR_W so MAX_LEN itself is representable.
  localparam logic [LEN_W:0]   MAX_LEN  = (LEN_W + 1)'(max_len(ADDR_W));
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [STATE_W-1:0] state_q;
  logic [SEL_W-1:0]   ch_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;

  logic [N_CH-1:0]    rr_req;
  logic               rr_valid;
  logic [SEL_W-1:0]   rr_idx;
  logic               grant_valid;
  logic [SEL_W-1:0]   next_ptr;
  logic [N_CH-1:0]    ch_onehot;
  logic [LEN_W-1:0]   raw_len;
  logic [LEN_W-1:0]   clamp_len;

  // Channel 0 bypasses the rotation; the arbiter only sees channels 1..N_CH-1.
  assign rr_req      = {i_ch_req[N_CH-1:1], 1'b0};
  assign grant_valid = i_ch_req[0] | rr_valid;
  assign next_ptr    = (rr_idx == SEL_W'(N_CH - 1)) ? SEL_W'(1) : rr_idx + SEL_W'(1);

  rr_arbiter #(
    .N     (N_CH),
    .IDX_W (SEL_W)
  ) u_rr (
    .req   (rr_req),
    .ptr   (ptr_q),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  assign ch_onehot = N_CH'(1) << ch_q;
  assign raw_len   = i_ch_len[ch_q*LEN_W +: LEN_W];
  assign clamp_len = ({1'b0, raw_len} > MAX_LEN) ? MAX_LEN[LEN_W-1:0] : raw_len;

  assign o_rd_sel    = ch_q;
  assign o_busy      = (state_q != ST_IDLE);
  // Read data arrives one cycle after o_rd_en, exactly when the write strobe is up.
  assign o_send_data = o_send_data_req ? i_rd_data[ch_q*8 +: 8] : 8'h00;

  // Transfer sequencer: grant, copy, send command, wait for completion.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      ch_q            <= '0;
      ptr_q           <= SEL_W'(1);
      len_q           <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      o_ch_ack        <= '0;
      o_ch_drop       <= '0;
      o_rd_en         <= 1'b0;
      o_rd_addr       <= '0;
      o_send_data_req <= 1'b0;
      o_send_wraddr   <= '0;
      o_send_req      <= 1'b0;
      o_send_num      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values and later lines can override defaults.
      o_ch_ack        <= '0;
      o_ch_drop       <= '0;
      o_send_req      <= 1'b0;
      o_send_data_req <= o_rd_en;
      o_send_wraddr   <= o_rd_addr;

      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            ch_q    <= i_ch_req[0] ? '0 : rr_idx;
            if (!i_ch_req[0]) ptr_q <= next_ptr;
            state_q <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if ((raw_len == '0) || !i_connect_state) begin
            o_ch_drop <= ch_onehot;
            state_q   <= ST_IDLE;
          end else begin
            len_q      <= clamp_len;
            o_send_num <= clamp_len;
            o_rd_en    <= 1'b1;
            o_rd_addr  <= '0;
            cnt_q      <= LEN_W'(1);
            state_q    <= ST_COPY;
          end
        end

        ST_COPY: begin
          if (!i_connect_state) begin
            o_ch_drop       <= ch_onehot;
            o_rd_en         <= 1'b0;
            o_send_data_req <= 1'b0;
            o_send_num      <= '0;
            state_q         <= ST_IDLE;
          end else if (cnt_q < len_q) begin
            o_rd_en   <= 1'b1;
            o_rd_addr <= cnt_q[ADDR_W-1:0];
            cnt_q     <= cnt_q + LEN_W'(1);
          end else begin
            o_rd_en <= 1'b0;
            state_q <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!i_connect_state) begin
            o_ch_drop       <= ch_onehot;
            o_send_data_req <= 1'b0;
            o_send_num      <= '0;
            state_q         <= ST_IDLE;
          end else begin
            o_send_req <= 1'b1;
            tmo_q      <= '0;
            state_q    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!i_connect_state) begin
            o_ch_drop  <= ch_onehot;
            o_send_num <= '0;
            tmo_q      <= '0;
            state_q    <= ST_IDLE;
          end else if (i_send_sig) begin
            // Completion wins over a timeout landing in the same cycle.
            o_ch_ack <= ch_onehot;
            tmo_q    <= '0;
            state_q  <= ST_DONE;
          end else if (tmo_q == TMO_LAST) begin
            o_ch_drop  <= ch_onehot;
            o_send_num <= '0;
            tmo_q      <= '0;
            state_q    <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        ST_DONE: begin
          o_send_num <= '0;
          state_q    <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_send_arbiter.sv
// Directed bench for eth_send_arbiter: reset state, arbitration order,
// a table of single-channel transfers, connection abort and reset-in-WAIT.
module tb_eth_send_arbiter;

  localparam int N_CH    = 3;
  localparam int LEN_W   = 16;
  localparam int ADDR_W  = 11;
  localparam int TMO_CYC = 100;

  logic                  clk;
  logic                  rst_n;
  logic [N_CH-1:0]       i_ch_req;
  logic [N_CH*LEN_W-1:0] i_ch_len;
  logic [N_CH-1:0]       o_ch_ack;
  logic [N_CH-1:0]       o_ch_drop;
  logic                  o_rd_en;
  logic [1:0]            o_rd_sel;
  logic [ADDR_W-1:0]     o_rd_addr;
  logic [N_CH*8-1:0]     rd_data;
  logic                  o_send_data_req;
  logic [7:0]            o_send_data;
  logic [ADDR_W-1:0]     o_send_wraddr;
  logic                  o_send_req;
  logic [LEN_W-1:0]      o_send_num;
  logic                  i_send_sig;
  logic                  i_connect_state;
  logic                  o_busy;

  eth_send_arbiter #(
    .N_CH    (N_CH),
    .LEN_W   (LEN_W),
    .ADDR_W  (ADDR_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .i_clk_50m       (clk),
    .i_rst_n         (rst_n),
    .i_ch_req        (i_ch_req),
    .i_ch_len        (i_ch_len),
    .o_ch_ack        (o_ch_ack),
    .o_ch_drop       (o_ch_drop),
    .o_rd_en         (o_rd_en),
    .o_rd_sel        (o_rd_sel),
    .o_rd_addr       (o_rd_addr),
    .i_rd_data       (rd_data),
    .o_send_data_req (o_send_data_req),
    .o_send_data     (o_send_data),
    .o_send_wraddr   (o_send_wraddr),
    .o_send_req      (o_send_req),
    .o_send_num      (o_send_num),
    .i_send_sig      (i_send_sig),
    .i_connect_state (i_connect_state),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source byte for channel c at address a.
  function automatic logic [7:0] pat(input int c, input int a);
    return 8'((c * 67) ^ (a * 13) ^ 'h3C);
  endfunction

  // Source buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (o_rd_en) begin
      for (int c = 0; c < N_CH; c++) rd_data[c*8 +: 8] <= pat(c, int'(o_rd_addr));
    end
  end

  typedef struct {
    int ch;
    int len;
    bit conn;
    int sig_dly;      // 0: never answer o_send_req
    bit exp_ack;
    int exp_num;      // -1: no o_send_req expected
    int exp_reads;
    int exp_sreq_lat; // cycles from request to o_send_req
    int exp_out_lat;  // cycles from request to ack/drop
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rd, n_wr, rd_bad, wr_bad, n_sreq, sreq_cyc, last_num;
  int n_evt, out_cyc, out_ch, out_ack;
  int sig_dly = 0;
  int sig_cd  = 0;
  int order[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    n_rd = 0; n_wr = 0; rd_bad = 0; wr_bad = 0;
    n_sreq = 0; sreq_cyc = 0; last_num = -1;
    n_evt = 0; out_cyc = 0; out_ch = -1; out_ack = 0;
    sig_cd = 0;
  endtask

  task automatic set_len(input int c, input int len);
    i_ch_len[c*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // Advance to the next falling edge, log DUT activity, play the W5500 core
  // (send_sig after sig_dly cycles) and release requests on ack/drop.
  task automatic step();
    @(negedge clk);
    cyc++;
    i_send_sig = 1'b0;
    if (sig_cd > 0) begin
      sig_cd--;
      if (sig_cd == 0) i_send_sig = 1'b1;
    end
    if (o_rd_en) begin
      if (int'(o_rd_addr) != n_rd) rd_bad++;
      n_rd++;
    end
    if (o_send_data_req) begin
      if (int'(o_send_wraddr) != n_wr) wr_bad++;
      if (o_send_data != pat(int'(o_rd_sel), int'(o_send_wraddr))) wr_bad++;
      n_wr++;
    end
    if (o_send_req) begin
      n_sreq++;
      sreq_cyc = cyc;
      last_num = int'(o_send_num);
      if (sig_dly > 0) sig_cd = sig_dly;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (o_ch_ack[c] || o_ch_drop[c]) begin
        n_evt++;
        i_ch_req[c] = 1'b0;
        if (n_evt == 1) begin
          out_cyc = cyc;
          out_ch  = c;
          out_ack = int'(o_ch_ack[c]);
        end
        if (o_ch_ack[c]) order.push_back(c);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_rd_sel"}, int'(o_rd_sel), 0);
    check({tag, "_send_num"}, int'(o_send_num), 0);
    check({tag, "_strobes"},
          int'({o_rd_en, o_send_data_req, o_send_req, o_ch_ack, o_ch_drop}), 0);
    check({tag, "_addr_data"}, int'({o_rd_addr, o_send_wraddr, o_send_data}), 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int start;
    i_connect_state = v.conn;
    set_len(v.ch, v.len);
    sig_dly = v.sig_dly;
    clear_logs();
    i_ch_req[v.ch] = 1'b1;
    start = cyc;
    for (int t = 0; t < 3000 && n_evt == 0; t++) step();
    check($sformatf("v%0d_finished", k), n_evt, 1);
    step();
    step();
    check($sformatf("v%0d_single_pulse", k), n_evt, 1);
    check($sformatf("v%0d_channel", k), out_ch, v.ch);
    check($sformatf("v%0d_ack", k), out_ack, int'(v.exp_ack));
    check($sformatf("v%0d_out_lat", k), out_cyc - start, v.exp_out_lat);
    check($sformatf("v%0d_reads", k), n_rd, v.exp_reads);
    check($sformatf("v%0d_writes", k), n_wr, v.exp_reads);
    check($sformatf("v%0d_rd_seq_err", k), rd_bad, 0);
    check($sformatf("v%0d_wr_seq_err", k), wr_bad, 0);
    if (v.exp_num < 0) begin
      check($sformatf("v%0d_no_send_req", k), n_sreq, 0);
    end else begin
      check($sformatf("v%0d_send_req_cnt", k), n_sreq, 1);
      check($sformatf("v%0d_send_num", k), last_num, v.exp_num);
      check($sformatf("v%0d_sreq_lat", k), sreq_cyc - start, v.exp_sreq_lat);
    end
    check($sformatf("v%0d_idle_after", k), int'(o_busy), 0);
  endtask

  vec_t vecs[9];
  int   found;

  initial begin
    // Request at cycle s: reads s+2..s+1+len, o_send_req at s+len+3,
    // ack at o_send_req+sig_dly+1, timeout drop at o_send_req+100,
    // zero-length or disconnected drop at s+2.
    vecs[0] = '{ch:1, len:4,    conn:1, sig_dly:2,   exp_ack:1, exp_num:4,    exp_reads:4,    exp_sreq_lat:7,    exp_out_lat:10};
    vecs[1] = '{ch:2, len:0,    conn:1, sig_dly:1,   exp_ack:0, exp_num:-1,   exp_reads:0,    exp_sreq_lat:0,    exp_out_lat:2};
    vecs[2] = '{ch:0, len:1,    conn:1, sig_dly:1,   exp_ack:1, exp_num:1,    exp_reads:1,    exp_sreq_lat:4,    exp_out_lat:6};
    vecs[3] = '{ch:0, len:5,    conn:0, sig_dly:1,   exp_ack:0, exp_num:-1,   exp_reads:0,    exp_sreq_lat:0,    exp_out_lat:2};
    vecs[4] = '{ch:2, len:3000, conn:1, sig_dly:1,   exp_ack:1, exp_num:2048, exp_reads:2048, exp_sreq_lat:2051, exp_out_lat:2053};
    vecs[5] = '{ch:1, len:2048, conn:1, sig_dly:3,   exp_ack:1, exp_num:2048, exp_reads:2048, exp_sreq_lat:2051, exp_out_lat:2055};
    vecs[6] = '{ch:1, len:3,    conn:1, sig_dly:0,   exp_ack:0, exp_num:3,    exp_reads:3,    exp_sreq_lat:6,    exp_out_lat:106};
    vecs[7] = '{ch:2, len:2,    conn:1, sig_dly:99,  exp_ack:1, exp_num:2,    exp_reads:2,    exp_sreq_lat:5,    exp_out_lat:105};
    vecs[8] = '{ch:2, len:2,    conn:1, sig_dly:100, exp_ack:0, exp_num:2,    exp_reads:2,    exp_sreq_lat:5,    exp_out_lat:105};

    rst_n = 1'b0;
    i_ch_req = '0;
    i_ch_len = '0;
    i_send_sig = 1'b0;
    i_connect_state = 1'b1;
    clear_logs();

    // Reset state.
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Arbitration: ch0 strict priority, then rotation over 1..2.
    sig_dly = 1;
    set_len(0, 2);
    set_len(1, 3);
    set_len(2, 1);
    clear_logs();
    order.delete();
    i_ch_req = 3'b111;
    for (int t = 0; t < 300 && order.size() < 3; t++) step();
    check("arb_round1_count", order.size(), 3);
    check("arb_round1_first", (order.size() > 0) ? order[0] : -1, 0);
    check("arb_round1_second", (order.size() > 1) ? order[1] : -1, 1);
    check("arb_round1_third", (order.size() > 2) ? order[2] : -1, 2);

    order.delete();
    i_ch_req[1] = 1'b1;
    for (int t = 0; t < 100 && order.size() < 1; t++) step();
    check("arb_solo_ch1", (order.size() > 0) ? order[0] : -1, 1);

    // Last served non-zero channel is 1, so 2 goes before 1.
    order.delete();
    i_ch_req[1] = 1'b1;
    i_ch_req[2] = 1'b1;
    for (int t = 0; t < 200 && order.size() < 2; t++) step();
    check("arb_round2_count", order.size(), 2);
    check("arb_round2_first", (order.size() > 0) ? order[0] : -1, 2);
    check("arb_round2_second", (order.size() > 1) ? order[1] : -1, 1);
    step();

    // Single-channel transfer table.
    for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

    // Connection lost while copying byte 2.
    i_connect_state = 1'b1;
    sig_dly = 1;
    set_len(1, 6);
    clear_logs();
    i_ch_req[1] = 1'b1;
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      step();
      if (o_rd_en && (o_rd_addr == ADDR_W'(2))) found = 1;
    end
    check("abort_reached_byte2", found, 1);
    i_connect_state = 1'b0;
    step();
    check("abort_drop_next_cycle", int'(o_ch_drop), 2);
    step();
    step();
    step();
    check("abort_single_drop", n_evt, 1);
    check("abort_no_send_req", n_sreq, 0);
    check("abort_idle", int'(o_busy), 0);
    i_connect_state = 1'b1;
    step();

    // Reset asserted while waiting for completion.
    sig_dly = 0;
    set_len(1, 2);
    clear_logs();
    i_ch_req[1] = 1'b1;
    for (int t = 0; t < 50 && n_sreq == 0; t++) step();
    check("rstwait_send_req_seen", n_sreq, 1);
    step();
    step();
    step();
    check("rstwait_busy_before", int'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstwait");
    i_ch_req = '0;
    step();
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) step();
    check("rstwait_no_pulse", n_evt, 0);
    check("rstwait_idle", int'(o_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
